// File: rtl/mic_pkg.sv
// Shared constants and types for the I2S microphone sample path.
package mic_pkg;
  localparam int unsigned MIC_DW = 18;
  localparam logic [MIC_DW-1:0] MIC_OFFSET = 18'h20000;
  typedef logic [MIC_DW-1:0] mic_sample_t;
endpackage

// File: rtl/mic_sample_ram.sv
// DEPTH x DW sample storage: one synchronous write port, asynchronous read.
module mic_sample_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned DW    = 18,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/mic_sample_fifo.sv
// Captures one receiver sample per in_rdy rising edge into a FWFT FIFO.
// Optional MIC_PEAK_EN adds a peak-magnitude tracker (peak, clr_peak).
module mic_sample_fifo
  import mic_pkg::*;
#(
  parameter int unsigned DW    = MIC_DW,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned LW    = $clog2(DEPTH) + 1
) (
  input  logic          dclk,
  input  logic          rst_n,
  input  logic [DW-1:0] in_data,
  input  logic          in_rdy,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          overflow,
  input  logic          clr_ovf
`ifdef MIC_PEAK_EN
  ,
  output logic [DW-2:0] peak,
  input  logic          clr_peak
`endif
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  logic          rdy_q;
  logic [AW-1:0] wptr, rptr;
  logic [DW-1:0] rd_data;
  logic          push, pop, accept, drop;

  assign push   = in_rdy & ~rdy_q;
  assign pop    = out_valid & out_ready;
  // When full, a coincident pop frees the slot the push writes into.
  assign accept = push & (~full | pop);
  assign drop   = push & full & ~pop;

  assign out_valid = (level != '0);
  assign full      = (level == LVL_FULL);
  assign out_data  = out_valid ? rd_data : '0;

  mic_sample_ram #(
    .DEPTH (DEPTH),
    .DW    (DW),
    .AW    (AW)
  ) u_ram (
    .clk   (dclk),
    .we    (accept),
    .waddr (wptr),
    .wdata (in_data),
    .raddr (rptr),
    .rdata (rd_data)
  );

  always_ff @(posedge dclk) begin
    if (!rst_n) begin
      rdy_q    <= 1'b1;
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      rdy_q <= in_rdy;
      if (accept) wptr <= wptr + 1'b1;
      if (pop)    rptr <= rptr + 1'b1;
      unique case ({accept, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

`ifdef MIC_PEAK_EN
  logic [DW-1:0] diff;
  logic [DW-2:0] mag;

  // Offset-binary to magnitude; only the most negative code saturates.
  always_comb begin
    diff = (in_data >= DW'(MIC_OFFSET)) ? in_data - DW'(MIC_OFFSET)
                                        : DW'(MIC_OFFSET) - in_data;
    mag  = diff[DW-1] ? '1 : diff[DW-2:0];
  end

  always_ff @(posedge dclk) begin
    if (!rst_n) begin
      peak <= '0;
    end else if (clr_peak) begin
      peak <= accept ? mag : '0;
    end else if (accept && (mag > peak)) begin
      peak <= mag;
    end
  end
`endif
endmodule

// File: tb/tb_mic_sample_fifo.sv
// Directed self-checking bench for mic_sample_fifo (define MIC_PEAK_EN to cover peak).
module tb_mic_sample_fifo;
  localparam int unsigned DW = 18;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned LW = 5;

  logic          dclk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] in_data;
  logic          in_rdy;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [LW-1:0] level;
  logic          full;
  logic          overflow;
  logic          clr_ovf;
`ifdef MIC_PEAK_EN
  logic [DW-2:0] peak;
  logic          clr_peak;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 dclk = ~dclk;

  mic_sample_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .LW    (LW)
  ) dut (
    .dclk      (dclk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_rdy    (in_rdy),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .full      (full),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
`ifdef MIC_PEAK_EN
    ,
    .peak      (peak),
    .clr_peak  (clr_peak)
`endif
  );

  task automatic tick();
    @(posedge dclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // One frame: in_rdy low for a cycle, then high; the push lands on the second edge.
  task automatic frame(input logic [DW-1:0] v);
    in_rdy  = 1'b0;
    in_data = v;
    tick();
    in_rdy = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; in_rdy = 1'b1; in_data = '0; out_ready = 1'b0; clr_ovf = 1'b0;
`ifdef MIC_PEAK_EN
    clr_peak = 1'b0;
`endif
    tick(); tick();
    chk("rst_level", 32'(level), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_data", 32'(out_data), 0);
`ifdef MIC_PEAK_EN
    chk("rst_peak", 32'(peak), 0);
`endif

    // in_rdy already high at reset release must not push
    rst_n = 1'b1;
    repeat (40) tick();
    chk("hold_level", 32'(level), 0);
    chk("hold_valid", 32'(out_valid), 0);

    // single push, one-cycle latency
    in_rdy = 1'b0; tick();
    in_data = 18'h2ABCD; in_rdy = 1'b1; tick();
    chk("one_valid", 32'(out_valid), 1);
    chk("one_data", 32'(out_data), 32'h2ABCD);
    chk("one_level", 32'(level), 1);
    repeat (5) tick();
    chk("one_hold_level", 32'(level), 1);
    chk("one_hold_data", 32'(out_data), 32'h2ABCD);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("one_pop_level", 32'(level), 0);
    chk("one_pop_valid", 32'(out_valid), 0);

    // fill to 16, 17th dropped
    for (int i = 1; i <= 16; i++) frame(DW'(i));
    chk("fill_level", 32'(level), 16);
    chk("fill_full", 32'(full), 1);
    chk("fill_ovf", 32'(overflow), 0);
    frame(18'd17);
    chk("drop_level", 32'(level), 16);
    chk("drop_ovf", 32'(overflow), 1);
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      chk($sformatf("drain_%0d", i), 32'(out_data), 32'(i));
      tick();
    end
    out_ready = 1'b0;
    chk("drain_valid", 32'(out_valid), 0);
    chk("drain_level", 32'(level), 0);
    chk("ovf_sticky", 32'(overflow), 1);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    chk("ovf_clr", 32'(overflow), 0);

    // full with coincident push and pop, then drop coinciding with clr_ovf
    for (int i = 1; i <= 16; i++) frame(DW'(32'h100 + i));
    in_rdy = 1'b0; in_data = 18'h3FFFF; tick();
    in_rdy = 1'b1; out_ready = 1'b1; tick();
    out_ready = 1'b0;
    chk("pp_ovf", 32'(overflow), 0);
    chk("pp_level", 32'(level), 16);
    chk("pp_head", 32'(out_data), 32'h102);
    in_rdy = 1'b0; in_data = 18'h12345; tick();
    in_rdy = 1'b1; clr_ovf = 1'b1; tick();
    clr_ovf = 1'b0;
    chk("setwins_ovf", 32'(overflow), 1);
    chk("setwins_level", 32'(level), 16);
    out_ready = 1'b1;
    for (int i = 2; i <= 16; i++) begin
      chk($sformatf("pp_drain_%0d", i), 32'(out_data), 32'h100 + i);
      tick();
    end
    chk("pp_last", 32'(out_data), 32'h3FFFF);
    tick();
    chk("pp_empty", 32'(out_valid), 0);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;

    // streaming with out_ready held high; 40 samples wrap pointers
    for (int i = 0; i < 40; i++) begin
      in_rdy = 1'b0; in_data = DW'(32'h200 + i); tick();
      chk($sformatf("stream_gap_%0d", i), 32'(level), 0);
      in_rdy = 1'b1; tick();
      chk($sformatf("stream_data_%0d", i), 32'(out_data), 32'h200 + i);
      chk($sformatf("stream_level_%0d", i), 32'(level), 1);
    end
    tick();
    chk("stream_end_valid", 32'(out_valid), 0);
    chk("stream_ovf", 32'(overflow), 0);
    out_ready = 1'b0;

    // reset mid-operation discards queued samples
    for (int i = 0; i < 3; i++) frame(DW'(32'h300 + i));
    chk("mid_level_pre", 32'(level), 3);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("mid_level", 32'(level), 0);
    chk("mid_valid", 32'(out_valid), 0);
    chk("mid_data", 32'(out_data), 0);

`ifdef MIC_PEAK_EN
    frame(18'h20010);
    frame(18'h1FF00);
    frame(18'h20005);
    chk("peak_max", 32'(peak), 32'h00100);
    clr_peak = 1'b1; tick(); clr_peak = 1'b0;
    chk("peak_clr", 32'(peak), 0);
    in_rdy = 1'b0; in_data = 18'h00000; tick();
    in_rdy = 1'b1; clr_peak = 1'b1; tick(); clr_peak = 1'b0;
    chk("peak_clr_push", 32'(peak), 32'h1FFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
